// File: rtl/circuit5_seq_pkg.sv
// Shared types and defaults for the circuit5 multi-cycle sequencer.
package circuit5_seq_pkg;

   localparam int unsigned DATAW_DEF = 64;
   localparam int unsigned OUTW_DEF  = 32;
   localparam int unsigned STATEW    = 3;
   localparam int unsigned ALUOPW    = 2;

   typedef enum logic [STATEW-1:0] {
      IDLE  = 3'd0,
      S_D   = 3'd1,
      S_E   = 3'd2,
      S_F   = 3'd3,
      S_CMP = 3'd4,
      S_OUT = 3'd5,
      DONE  = 3'd6
   } state_e;

   typedef enum logic [ALUOPW-1:0] {
      ALU_ADD = 2'd0,
      ALU_SUB = 2'd1,
      ALU_CMP = 2'd2
   } alu_op_e;

endpackage

// File: rtl/circuit5_seq_shared_alu.sv
// Shared signed add/sub/compare unit; one operation per cycle, purely combinational.
module shared_alu
   import circuit5_seq_pkg::*;
#(
   parameter int unsigned DATAW = DATAW_DEF
) (
   input  logic [DATAW-1:0] opa,
   input  logic [DATAW-1:0] opb,
   input  alu_op_e          op,
   output logic [DATAW-1:0] res,
   output logic             lt,
   output logic             eq
);

   always_comb begin
      res = opa + opb;
      case (op)
         ALU_SUB, ALU_CMP: res = opa - opb;
         default:          res = opa + opb;
      endcase
   end

   // True signed ordering, independent of the wrapped difference.
   assign lt = ($signed(opa) < $signed(opb));
   assign eq = (opa == opb);

endmodule

// File: rtl/circuit5_seq.sv
// circuit5 dataflow sequenced over one shared ALU: d, e, f, compare, then select/shift outputs.
module circuit5_seq
   import circuit5_seq_pkg::*;
#(
   parameter int unsigned DATAW = DATAW_DEF,
   parameter int unsigned OUTW  = OUTW_DEF
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             start,
   input  logic [DATAW-1:0] a,
   input  logic [DATAW-1:0] b,
   input  logic [DATAW-1:0] c,
   output logic             busy,
   output logic             done,
   output logic [OUTW-1:0]  x,
   output logic [OUTW-1:0]  z
);

   state_e             state_q, state_d;
   logic [DATAW-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
   logic [DATAW-1:0]   d_q, d_d, e_q, e_d, f_q, f_d;
   logic               dlte_q, dlte_d, deq_q, deq_d;
   logic               busy_q, busy_d, done_q, done_d;
   logic [OUTW-1:0]    x_q, x_d, z_q, z_d;

   logic [DATAW-1:0]   alu_opa_c, alu_opb_c, alu_res_c;
   alu_op_e            alu_op_c;
   logic               alu_lt_c, alu_eq_c;
   logic [DATAW-1:0]   g_c, h_c;

   shared_alu #(.DATAW(DATAW)) u_alu (
      .opa (alu_opa_c),
      .opb (alu_opb_c),
      .op  (alu_op_c),
      .res (alu_res_c),
      .lt  (alu_lt_c),
      .eq  (alu_eq_c)
   );

   assign g_c = dlte_q ? e_q : d_q;
   assign h_c = deq_q  ? f_q : g_c;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         d_q     <= '0;
         e_q     <= '0;
         f_q     <= '0;
         dlte_q  <= 1'b0;
         deq_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         x_q     <= '0;
         z_q     <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         d_q     <= d_d;
         e_q     <= e_d;
         f_q     <= f_d;
         dlte_q  <= dlte_d;
         deq_q   <= deq_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         x_q     <= x_d;
         z_q     <= z_d;
      end
   end

   // Next state, ALU operand routing and register updates.
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      c_d       = c_q;
      d_d       = d_q;
      e_d       = e_q;
      f_d       = f_q;
      dlte_d    = dlte_q;
      deq_d     = deq_q;
      x_d       = x_q;
      z_d       = z_q;
      alu_opa_c = a_q;
      alu_opb_c = b_q;
      alu_op_c  = ALU_ADD;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               c_d     = c;
               state_d = S_D;
            end
         end
         S_D: begin
            d_d     = alu_res_c;
            state_d = S_E;
         end
         S_E: begin
            alu_opb_c = c_q;
            e_d       = alu_res_c;
            state_d   = S_F;
         end
         S_F: begin
            alu_op_c = ALU_SUB;
            f_d      = alu_res_c;
            state_d  = S_CMP;
         end
         S_CMP: begin
            alu_opa_c = d_q;
            alu_opb_c = e_q;
            alu_op_c  = ALU_CMP;
            dlte_d    = alu_lt_c;
            deq_d     = alu_eq_c;
            state_d   = S_OUT;
         end
         S_OUT: begin
            x_d     = OUTW'(h_c << dlte_q);
            z_d     = OUTW'($signed(g_c) >>> deq_q);
            state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Status flags are registered against the state being entered.
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   assign busy = busy_q;
   assign done = done_q;
   assign x    = x_q;
   assign z    = z_q;

endmodule

// File: tb/tb_circuit5_seq.sv
// Directed self-checking bench for circuit5_seq.
module tb_circuit5_seq;

   logic        Clk, Rst, start;
   logic [63:0] a, b, c;
   logic        busy, done;
   logic [31:0] x, z;

   int tests_run = 0;
   int tests_failed = 0;

   circuit5_seq dut (
      .Clk   (Clk),
      .Rst   (Rst),
      .start (start),
      .a     (a),
      .b     (b),
      .c     (c),
      .busy  (busy),
      .done  (done),
      .x     (x),
      .z     (z)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model(input logic [63:0] ia, input logic [63:0] ib,
                                 input logic [63:0] ic,
                                 output logic [31:0] ox, output logic [31:0] oz);
      logic [63:0] d, e, f, g, h, sx, sz;
      logic lt, eq;
      d  = ia + ib;
      e  = ia + ic;
      f  = ia - ib;
      lt = $signed(d) < $signed(e);
      eq = (d == e);
      g  = lt ? e : d;
      h  = eq ? f : g;
      sx = lt ? {h[62:0], 1'b0} : h;
      sz = eq ? {g[63], g[63:1]} : g;
      ox = sx[31:0];
      oz = sz[31:0];
   endfunction

   task automatic run_op(input string tag, input logic [63:0] ia, input logic [63:0] ib,
                         input logic [63:0] ic, input logic [31:0] ex, input logic [31:0] ez);
      @(negedge Clk);
      a = ia; b = ib; c = ic; start = 1'b1;
      @(posedge Clk);
      #1;
      start = 1'b0;
      a = ~ia; b = ~ib; c = ~ic;
      @(negedge Clk);
      check({tag, "_busy0"}, 64'(busy), 64'd1);
      check({tag, "_done0"}, 64'(done), 64'd0);
      for (int k = 1; k <= 4; k++) begin
         @(negedge Clk);
         if (done !== 1'b0 || busy !== 1'b1) check({tag, "_midflags"}, {62'd0, busy, done}, 64'd2);
      end
      @(negedge Clk);
      check({tag, "_done"}, 64'(done), 64'd1);
      check({tag, "_busy5"}, 64'(busy), 64'd1);
      check({tag, "_x"}, 64'(x), 64'(ex));
      check({tag, "_z"}, 64'(z), 64'(ez));
      @(negedge Clk);
      check({tag, "_done_end"}, 64'(done), 64'd0);
      check({tag, "_busy_end"}, 64'(busy), 64'd0);
   endtask

   logic [63:0] va [0:20];
   logic [63:0] vb [0:20];
   logic [63:0] vc [0:20];
   logic [31:0] mx, mz;
   bit          saw_done;

   initial begin
      Rst = 1'b1; start = 1'b0; a = '0; b = '0; c = '0;
      #12;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_x", 64'(x), 64'd0);
      check("rst_z", 64'(z), 64'd0);
      @(negedge Clk);
      Rst = 1'b0;

      run_op("basic", 64'd5, 64'd3, 64'd1, 32'd8, 32'd8);
      run_op("lt", 64'd1, 64'd2, 64'd10, 32'd22, 32'd11);
      run_op("eq", 64'd4, 64'd7, 64'd7, 32'hFFFF_FFFD, 32'd5);
      run_op("wrap", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFF);

      // start held high, operands changing every cycle: accept every 7th edge only
      for (int k = 0; k <= 20; k++) begin
         va[k] = 64'(k * 5 + 2);
         vb[k] = 64'(k * k) - 64'd7;
         vc[k] = 64'(k * 3);
         a = va[k]; b = vb[k]; c = vc[k]; start = 1'b1;
         @(posedge Clk);
         @(negedge Clk);
         check($sformatf("cont_done_%0d", k), 64'(done), (k % 7 == 5) ? 64'd1 : 64'd0);
         if (k % 7 == 5) begin
            model(va[k-5], vb[k-5], vc[k-5], mx, mz);
            check($sformatf("cont_x_%0d", k), 64'(x), 64'(mx));
            check($sformatf("cont_z_%0d", k), 64'(z), 64'(mz));
         end
      end
      start = 1'b0;
      repeat (8) @(negedge Clk);

      // asynchronous reset in S_F: outputs clear at once, no done afterwards
      @(negedge Clk);
      a = 64'd9; b = 64'd2; c = 64'd1; start = 1'b1;
      @(posedge Clk);
      #1 start = 1'b0;
      @(posedge Clk);
      @(posedge Clk);
      #3 Rst = 1'b1;
      #1;
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_done", 64'(done), 64'd0);
      check("arst_x", 64'(x), 64'd0);
      check("arst_z", 64'(z), 64'd0);
      @(negedge Clk);
      Rst = 1'b0;
      saw_done = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge Clk);
         if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      end
      check("arst_no_done", 64'(saw_done), 64'd0);

      run_op("post_rst", 64'd5, 64'd3, 64'd1, 32'd8, 32'd8);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
